sb_io_pad: RTL and testbench

Behavioural model of the iCE40 programmable I/O cell. It connects one bidirectional package pin to fabric logic. Input and output paths are each selectable as combinational, registered, latched or DDR, with an optional weak pull-up. In the Apollo core it conditions the `next` and `rst` push-buttons, using mode 6'b1010_01 with pull-up, before they reach debounce and reset logic.

---
 rtl/sb_io_pad_pkg.sv | 24 ++
 rtl/sb_io_pad.sv | 187 ++++++++++++++++++
 tb/tb_sb_io_pad.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sb_io_pad_pkg.sv
// Purpose : shared PIN_TYPE field encodings for the programmable pad cell.
// Latency : n/a (constants only).
// Backpres: n/a.
package sb_io_pad_pkg;

    // Input mode, PIN_TYPE[1:0]
    localparam logic [1:0] IN_REG_DDR   = 2'b00;
    localparam logic [1:0] IN_SIMPLE    = 2'b01;
    localparam logic [1:0] IN_REG_LATCH = 2'b10;
    localparam logic [1:0] IN_LATCH     = 2'b11;

    // Output data select, PIN_TYPE[3:2]
    localparam logic [1:0] OUT_DDR      = 2'b00;
    localparam logic [1:0] OUT_REG      = 2'b01;
    localparam logic [1:0] OUT_SIMPLE   = 2'b10;
    localparam logic [1:0] OUT_REG_INV  = 2'b11;

    // Output enable select, PIN_TYPE[5:4]
    localparam logic [1:0] OE_NEVER     = 2'b00;
    localparam logic [1:0] OE_ALWAYS    = 2'b01;
    localparam logic [1:0] OE_SIMPLE    = 2'b10;
    localparam logic [1:0] OE_REG       = 2'b11;

endpackage

// File: rtl/sb_io_pad.sv
// Purpose : behavioural iCE40 I/O cell; one bidirectional pad with selectable comb/reg/latch/DDR paths.
// Latency : 0 cycles on combinational paths, 1 active edge on registered paths, half a cycle for DDR out.
// Backpres: none; CLOCK_ENABLE=0 freezes every register, rst wins over CE and latch hold.
module sb_io_pad
    import sb_io_pad_pkg::*;
#(
    parameter logic [5:0] PIN_TYPE    = 6'b000000,
    parameter logic       PULLUP      = 1'b0,
    parameter logic       NEG_TRIGGER = 1'b0
) (
    input  logic clk,
    input  logic rst,
    inout  wire  PACKAGE_PIN,
    input  logic CLOCK_ENABLE,
    input  logic LATCH_INPUT_VALUE,
    input  logic OUTPUT_ENABLE,
    input  logic D_OUT_0,
    input  logic D_OUT_1,
    output logic D_IN_0,
    output logic D_IN_1
);

    localparam logic [1:0] IN_MODE  = PIN_TYPE[1:0];
    localparam logic [1:0] OUT_MODE = PIN_TYPE[3:2];
    localparam logic [1:0] OE_MODE  = PIN_TYPE[5:4];

    // Every register in the cell runs on this clock; inverting it mirrors all edges.
    logic clk_a;
    assign clk_a = clk ^ NEG_TRIGGER;

    logic drive_w;     // pad is being driven by this cell
    logic out_w;       // value on the pad when driven
    logic out_rise_w;  // value the pad carries in the phase opened by a rising edge
    logic out_fall_w;  // value the pad carries in the phase opened by a falling edge

    // ---------------- OE path ----------------
    generate
        if (OE_MODE == OE_REG) begin : g_oe_reg
            logic oe_q;
            logic oe_d;
            // Next enable: follow OUTPUT_ENABLE only while the clock is enabled.
            always_comb begin
                oe_d = oe_q;
                if (CLOCK_ENABLE) oe_d = OUTPUT_ENABLE;
            end
            // Enable register; reset leaves the pad floating.
            always_ff @(posedge clk_a) begin
                if (rst) oe_q <= 1'b0;
                else     oe_q <= oe_d;
            end
            assign drive_w = oe_q;
        end else if (OE_MODE == OE_SIMPLE) begin : g_oe_simple
            assign drive_w = OUTPUT_ENABLE;
        end else if (OE_MODE == OE_ALWAYS) begin : g_oe_always
            assign drive_w = 1'b1;
        end else begin : g_oe_never
            assign drive_w = 1'b0;
        end
    endgenerate

    // ---------------- Output path ----------------
    generate
        if (OE_MODE == OE_NEVER) begin : g_out_none
            // Pad never driven: no output registers are built.
            assign out_w      = 1'b0;
            assign out_rise_w = 1'b0;
            assign out_fall_w = 1'b0;
        end else if (OUT_MODE == OUT_DDR) begin : g_out_ddr
            logic rise_q, rise_d;
            logic fall_q, fall_d;
            // Next DDR data: capture both halves only while the clock is enabled.
            always_comb begin
                rise_d = rise_q;
                fall_d = fall_q;
                if (CLOCK_ENABLE) begin
                    rise_d = D_OUT_0;
                    fall_d = D_OUT_1;
                end
            end
            // Rising-edge half.
            always_ff @(posedge clk_a) begin
                if (rst) rise_q <= 1'b0;
                else     rise_q <= rise_d;
            end
            // Falling-edge half; reset clears it at the next falling edge.
            always_ff @(negedge clk_a) begin
                if (rst) fall_q <= 1'b0;
                else     fall_q <= fall_d;
            end
            assign out_w      = clk_a ? rise_q : fall_q;
            assign out_rise_w = rise_q;
            assign out_fall_w = fall_q;
        end else if (OUT_MODE == OUT_SIMPLE) begin : g_out_simple
            assign out_w      = D_OUT_0;
            assign out_rise_w = D_OUT_0;
            assign out_fall_w = D_OUT_0;
        end else begin : g_out_reg
            logic out_q, out_d;
            // Next output data, held while the clock is disabled.
            always_comb begin
                out_d = out_q;
                if (CLOCK_ENABLE) out_d = D_OUT_0;
            end
            // Output data register.
            always_ff @(posedge clk_a) begin
                if (rst) out_q <= 1'b0;
                else     out_q <= out_d;
            end
            assign out_w      = (OUT_MODE == OUT_REG_INV) ? ~out_q : out_q;
            assign out_rise_w = out_w;
            assign out_fall_w = out_w;
        end
    endgenerate

    assign PACKAGE_PIN = drive_w ? out_w : 1'bz;

    generate
        if (PULLUP) begin : g_pullup
            pullup u_pullup (PACKAGE_PIN);
        end
    endgenerate

    // Pad value seen by the input path. When this cell drives, use the driven
    // value directly; the DDR pad toggles with the clock itself, so the input
    // registers take the level of the phase their edge opens.
    logic pv_w, pv_rise_w, pv_fall_w;
    assign pv_w      = drive_w ? out_w      : PACKAGE_PIN;
    assign pv_rise_w = drive_w ? out_rise_w : PACKAGE_PIN;
    assign pv_fall_w = drive_w ? out_fall_w : PACKAGE_PIN;

    // ---------------- Input path ----------------
    generate
        if (IN_MODE == IN_SIMPLE) begin : g_in_simple
            assign D_IN_0 = pv_w;
            assign D_IN_1 = 1'b0;
        end else if (IN_MODE == IN_LATCH) begin : g_in_latch
            logic lat_q, lat_d;
            // Value presented to the latch.
            always_comb begin
                lat_d = pv_w;
            end
            // Transparent while LATCH_INPUT_VALUE is low, holds when high.
            always_latch begin
                if (!LATCH_INPUT_VALUE) lat_q <= lat_d;
            end
            assign D_IN_0 = LATCH_INPUT_VALUE ? lat_q : pv_w;
            assign D_IN_1 = 1'b0;
        end else begin : g_in_reg
            logic in0_q, in0_d;
            // Next rising-edge sample; mode 10 additionally holds on LATCH_INPUT_VALUE.
            always_comb begin
                in0_d = in0_q;
                if (CLOCK_ENABLE && !((IN_MODE == IN_REG_LATCH) && LATCH_INPUT_VALUE))
                    in0_d = pv_rise_w;
            end
            // Rising-edge input register.
            always_ff @(posedge clk_a) begin
                if (rst) in0_q <= 1'b0;
                else     in0_q <= in0_d;
            end
            assign D_IN_0 = in0_q;

            if (IN_MODE == IN_REG_DDR) begin : g_in_fall
                logic in1_q, in1_d;
                // Next falling-edge sample.
                always_comb begin
                    in1_d = in1_q;
                    if (CLOCK_ENABLE) in1_d = pv_fall_w;
                end
                // Falling-edge input register.
                always_ff @(negedge clk_a) begin
                    if (rst) in1_q <= 1'b0;
                    else     in1_q <= in1_d;
                end
                assign D_IN_1 = in1_q;
            end else begin : g_in_nofall
                assign D_IN_1 = 1'b0;
            end
        end
    endgenerate

    // Some inputs and taps go unused in particular PIN_TYPE settings.
    logic unused_w;
    assign unused_w = ^{clk, rst, CLOCK_ENABLE, LATCH_INPUT_VALUE, OUTPUT_ENABLE,
                        D_OUT_0, D_OUT_1, pv_w, pv_rise_w, pv_fall_w};

endmodule

// File: tb/tb_sb_io_pad.sv
// Purpose : self-checking bench for sb_io_pad across several PIN_TYPE configurations.
// Latency : directed checks plus a randomized run against a cycle-level expectation model.
// Backpres: n/a.
module tb_sb_io_pad;

    logic clk = 1'b0;
    logic rst, ce, lat, oe, d0, d1;
    logic pa_en, pa_val, pd_en, pd_val;

    wire pa, pb, pc, pd, pe;
    logic btn_din0, btn_din1, reg_din0, reg_din1, ddr_din0, ddr_din1;
    logic lat_din0, lat_din1, neg_din0, neg_din1;

    int n_tests = 0;
    int n_fail  = 0;

    assign pa = pa_en ? pa_val : 1'bz;
    assign pd = pd_en ? pd_val : 1'bz;

    always #5 clk = ~clk;

    // Push-button conditioning: comb OE, comb out, comb in, pull-up.
    sb_io_pad #(.PIN_TYPE(6'b101001), .PULLUP(1'b1), .NEG_TRIGGER(1'b0)) u_btn (
        .clk(clk), .rst(rst), .PACKAGE_PIN(pa), .CLOCK_ENABLE(ce),
        .LATCH_INPUT_VALUE(lat), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1),
        .D_IN_0(btn_din0), .D_IN_1(btn_din1));

    // Always driven, registered out, registered in.
    sb_io_pad #(.PIN_TYPE(6'b010100), .PULLUP(1'b0), .NEG_TRIGGER(1'b0)) u_reg (
        .clk(clk), .rst(rst), .PACKAGE_PIN(pb), .CLOCK_ENABLE(ce),
        .LATCH_INPUT_VALUE(lat), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1),
        .D_IN_0(reg_din0), .D_IN_1(reg_din1));

    // Always driven, DDR out, registered in (loopback).
    sb_io_pad #(.PIN_TYPE(6'b010000), .PULLUP(1'b0), .NEG_TRIGGER(1'b0)) u_ddr (
        .clk(clk), .rst(rst), .PACKAGE_PIN(pc), .CLOCK_ENABLE(ce),
        .LATCH_INPUT_VALUE(lat), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1),
        .D_IN_0(ddr_din0), .D_IN_1(ddr_din1));

    // Never driven, latched input.
    sb_io_pad #(.PIN_TYPE(6'b000011), .PULLUP(1'b0), .NEG_TRIGGER(1'b0)) u_lat (
        .clk(clk), .rst(rst), .PACKAGE_PIN(pd), .CLOCK_ENABLE(ce),
        .LATCH_INPUT_VALUE(lat), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1),
        .D_IN_0(lat_din0), .D_IN_1(lat_din1));

    // Registered OE, inverted registered out, hold-able registered in, falling-edge clocked.
    sb_io_pad #(.PIN_TYPE(6'b111110), .PULLUP(1'b1), .NEG_TRIGGER(1'b1)) u_neg (
        .clk(clk), .rst(rst), .PACKAGE_PIN(pe), .CLOCK_ENABLE(ce),
        .LATCH_INPUT_VALUE(lat), .OUTPUT_ENABLE(oe), .D_OUT_0(d0), .D_OUT_1(d1),
        .D_IN_0(neg_din0), .D_IN_1(neg_din1));

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Expectation state for the randomized run.
    logic m_out, m_din0, m_din1;      // u_reg: pad level, rising sample, falling sample
    logic m_oe, m_nout, m_ndin;       // u_neg: enable, stored data, input sample
    logic npad;

    initial begin
        rst = 1'b1; ce = 1'b1; lat = 1'b0; oe = 1'b0; d0 = 1'b0; d1 = 1'b0;
        pa_en = 1'b0; pa_val = 1'b0; pd_en = 1'b0; pd_val = 1'b0;

        // ---- reset state ----
        do_reset();
        chk("rst_reg_din0", reg_din0, 1'b0);
        chk("rst_reg_din1", reg_din1, 1'b0);
        chk("rst_reg_pad",  pb,       1'b0);
        chk("rst_ddr_din0", ddr_din0, 1'b0);
        chk("rst_neg_din0", neg_din0, 1'b0);
        chk("rst_neg_pad",  pe,       1'b1);   // OE register 0 -> floating -> pull-up

        // ---- combinational button pad ----
        #1 chk("btn_pullup", btn_din0, 1'b1);
        pa_en = 1'b1; pa_val = 1'b0;
        #1 chk("btn_ext0", btn_din0, 1'b0);
        pa_en = 1'b0;
        oe = 1'b1; d0 = 1'b0;
        #1 chk("btn_drv0_pad", pa, 1'b0);
        chk("btn_drv0_din", btn_din0, 1'b0);
        d0 = 1'b1;
        #1 chk("btn_drv1_pad", pa, 1'b1);
        chk("btn_drv1_din", btn_din0, 1'b1);
        oe = 1'b0; d0 = 1'b0;
        #1 chk("btn_release", btn_din0, 1'b1);

        // ---- registered out / registered in ----
        d0 = 1'b0; ce = 1'b1;
        do_reset();
        d0 = 1'b1;
        @(posedge clk); #1;
        chk("reg_pad_1edge", pb, 1'b1);
        chk("reg_din_1edge", reg_din0, 1'b0);
        @(posedge clk); #1;
        chk("reg_din_2edge", reg_din0, 1'b1);
        chk("reg_din1_fall", reg_din1, 1'b1);
        ce = 1'b0; d0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("ce_freeze_pad", pb, 1'b1);
            chk("ce_freeze_din", reg_din0, 1'b1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_over_ce_pad", pb, 1'b0);
        chk("rst_over_ce_din", reg_din0, 1'b0);
        @(negedge clk); #1;
        chk("rst_over_ce_din1", reg_din1, 1'b0);
        rst = 1'b0; ce = 1'b1;

        // ---- DDR output with loopback ----
        d0 = 1'b1; d1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("ddr_hi", pc, 1'b1);
        @(negedge clk); #1;
        chk("ddr_lo", pc, 1'b0);
        chk("ddr_din0", ddr_din0, 1'b1);
        chk("ddr_din1", ddr_din1, 1'b0);
        d0 = 1'b0; d1 = 1'b1;
        @(posedge clk); #1;
        chk("ddr_hi2", pc, 1'b0);
        @(negedge clk); #1;
        chk("ddr_lo2", pc, 1'b1);
        @(posedge clk); @(negedge clk); #1;
        chk("ddr_din0_2", ddr_din0, 1'b0);
        chk("ddr_din1_2", ddr_din1, 1'b1);

        // ---- latched input ----
        pd_en = 1'b1; pd_val = 1'b1; lat = 1'b0;
        #1 chk("lat_transp", lat_din0, 1'b1);
        lat = 1'b1;
        #1 pd_val = 1'b0;
        #1 chk("lat_hold", lat_din0, 1'b1);
        lat = 1'b0;
        #1 chk("lat_release", lat_din0, 1'b0);
        pd_val = 1'b1;
        #1 chk("lat_follow", lat_din0, 1'b1);

        // ---- randomized run: u_reg (rising) and u_neg (falling, mirrored) ----
        d0 = 1'b0; lat = 1'b0; oe = 1'b0; ce = 1'b1;
        do_reset();
        m_out = 1'b0; m_din0 = 1'b0; m_din1 = 1'b0;
        m_oe = 1'b0; m_nout = 1'b0; m_ndin = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            d0  = 1'($urandom);
            oe  = 1'($urandom);
            lat = ($urandom_range(0, 3) == 0);
            ce  = ($urandom_range(0, 4) != 0);
            rst = ($urandom_range(0, 15) == 0);

            @(negedge clk);
            // u_reg falling sample sees the pad = its registered D_OUT_0.
            if (rst)     m_din1 = 1'b0;
            else if (ce) m_din1 = m_out;
            // u_neg active edge: pad level before the edge is inverted data or pull-up.
            npad = m_oe ? ~m_nout : 1'b1;
            if (rst) begin
                m_oe = 1'b0; m_nout = 1'b0; m_ndin = 1'b0;
            end else if (ce) begin
                if (!lat) m_ndin = npad;
                m_oe   = oe;
                m_nout = d0;
            end
            #1;
            chk("rnd_neg_din", neg_din0, m_ndin);
            chk("rnd_neg_pad", pe, m_oe ? ~m_nout : 1'b1);
            chk("rnd_neg_din1", neg_din1, 1'b0);
            chk("rnd_reg_din1", reg_din1, m_din1);

            @(posedge clk);
            if (rst) begin
                m_din0 = 1'b0; m_out = 1'b0;
            end else if (ce) begin
                m_din0 = m_out;
                m_out  = d0;
            end
            #1;
            chk("rnd_reg_din0", reg_din0, m_din0);
            chk("rnd_reg_pad", pb, m_out);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
